// File: rtl/ip_codma_pkg.sv
// Shared types and helpers for the CODMA bus arbiter: states, owner
// encoding, burst size codes and error codes.
package ip_codma_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_OWN,
    ARB_RELEASE,
    ARB_ERROR
  } arb_state_t;

  typedef enum logic {
    ARB_RD = 1'b0,
    ARB_WR = 1'b1
  } arb_owner_t;

  localparam logic [3:0] SIZE_2W = 4'd3;
  localparam logic [3:0] SIZE_6W = 4'd8;
  localparam logic [3:0] SIZE_8W = 4'd9;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_SIZE    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_BUS     = 2'd3;

  // Number of 64-bit beats for a size code; 0 flags an illegal code.
  function automatic logic [2:0] size_to_beats(input logic [3:0] code);
    logic [2:0] beats;
    case (code)
      SIZE_2W: beats = 3'd1;
      SIZE_6W: beats = 3'd3;
      SIZE_8W: beats = 3'd4;
      default: beats = 3'd0;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ip_codma_rr_picker.sv
// Two-way round-robin select between the read and write machines, with
// the last-owner history register that breaks ties.
module ip_codma_rr_picker
  import ip_codma_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_req,
  input  logic       wr_req,
  input  logic       update,
  input  arb_owner_t done_owner,
  output arb_owner_t pick
);

  arb_owner_t last_owner;

  // Write is the reset history so that read wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= ARB_WR;
    end else if (update) begin
      last_owner <= done_owner;
    end
  end

  always_comb begin
    pick = ARB_RD;
    if (rd_req && wr_req) begin
      pick = (last_owner == ARB_WR) ? ARB_RD : ARB_WR;
    end else if (wr_req) begin
      pick = ARB_WR;
    end
  end

endmodule

// File: rtl/ip_codma_bus_arbiter.sv
// Arbitrates the CODMA memory-bus master port between the read and write
// machines: round-robin pick, bus request, beat counting and error capture.
module ip_codma_bus_arbiter
  import ip_codma_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 9
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       stop_i,
  input  logic       rd_req_i,
  input  logic [3:0] rd_size_i,
  output logic       rd_grant_o,
  output logic       rd_done_o,
  input  logic       wr_req_i,
  input  logic [3:0] wr_size_i,
  output logic       wr_grant_o,
  output logic       wr_done_o,
  output logic       bus_req_o,
  output logic [3:0] bus_size_o,
  input  logic       bus_grant_i,
  input  logic       bus_beat_i,
  input  logic       bus_error_i,
  output logic       busy_o,
  output logic       error_o,
  output logic [1:0] err_code_o
);

  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_ONE   = CNT_W'(1);

  arb_state_t       state;
  arb_state_t       next_state;
  arb_owner_t       owner;
  arb_owner_t       pick;
  logic [2:0]       beats_need;
  logic [2:0]       beat_cnt;
  logic [CNT_W-1:0] tmo_cnt;
  logic [3:0]       sel_size;
  logic [2:0]       sel_beats;
  logic [1:0]       err_cause;
  logic             any_req;
  logic             latch;
  logic             timeout;
  logic             final_beat;

  logic             rd_grant_d;
  logic             rd_done_d;
  logic             wr_grant_d;
  logic             wr_done_d;
  logic             bus_req_d;
  logic [3:0]       bus_size_d;
  logic             busy_d;
  logic             error_d;
  logic [1:0]       err_code_d;

  ip_codma_rr_picker u_picker (
    .clk        (clk_i),
    .rst        (reset_i),
    .rd_req     (rd_req_i),
    .wr_req     (wr_req_i),
    .update     ((state == ARB_RELEASE) && !stop_i),
    .done_owner (owner),
    .pick       (pick)
  );

  assign any_req    = rd_req_i || wr_req_i;
  assign sel_size   = (pick == ARB_RD) ? rd_size_i : wr_size_i;
  assign sel_beats  = size_to_beats(sel_size);
  assign latch      = (state == ARB_IDLE) && !stop_i && any_req;
  assign timeout    = (tmo_cnt == TMO_LIMIT);
  assign final_beat = bus_beat_i && ((beat_cnt + 3'd1) == beats_need);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= ARB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Priority within each state: stop > bus error > timeout > grant/final beat.
  always_comb begin
    next_state = state;
    err_cause  = ERR_NONE;
    case (state)
      ARB_IDLE: begin
        if (any_req) begin
          if (sel_beats == 3'd0) begin
            next_state = ARB_ERROR;
            err_cause  = ERR_SIZE;
          end else begin
            next_state = ARB_REQ;
          end
        end
      end
      ARB_REQ: begin
        if (bus_error_i) begin
          next_state = ARB_ERROR;
          err_cause  = ERR_BUS;
        end else if (timeout) begin
          next_state = ARB_ERROR;
          err_cause  = ERR_TIMEOUT;
        end else if (bus_grant_i) begin
          next_state = ARB_OWN;
        end
      end
      ARB_OWN: begin
        if (bus_error_i) begin
          next_state = ARB_ERROR;
          err_cause  = ERR_BUS;
        end else if (timeout) begin
          next_state = ARB_ERROR;
          err_cause  = ERR_TIMEOUT;
        end else if (final_beat) begin
          next_state = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        if (bus_error_i) begin
          next_state = ARB_ERROR;
          err_cause  = ERR_BUS;
        end else begin
          next_state = ARB_IDLE;
        end
      end
      default: next_state = state;
    endcase
    if (stop_i) begin
      next_state = ARB_IDLE;
      err_cause  = ERR_NONE;
    end
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    bus_req_d  = (next_state == ARB_REQ) || (next_state == ARB_OWN);
    rd_grant_d = (next_state == ARB_OWN) && (owner == ARB_RD);
    wr_grant_d = (next_state == ARB_OWN) && (owner == ARB_WR);
    rd_done_d  = (next_state == ARB_RELEASE) && (owner == ARB_RD);
    wr_done_d  = (next_state == ARB_RELEASE) && (owner == ARB_WR);
    busy_d     = (next_state != ARB_IDLE);
    error_d    = (next_state == ARB_ERROR);
    bus_size_d = latch ? sel_size : bus_size_o;
    err_code_d = err_code_o;
    if (stop_i) begin
      err_code_d = ERR_NONE;
    end else if ((state != ARB_ERROR) && (next_state == ARB_ERROR)) begin
      err_code_d = err_cause;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_grant_o <= 1'b0;
      rd_done_o  <= 1'b0;
      wr_grant_o <= 1'b0;
      wr_done_o  <= 1'b0;
      bus_req_o  <= 1'b0;
      bus_size_o <= '0;
      busy_o     <= 1'b0;
      error_o    <= 1'b0;
      err_code_o <= '0;
    end else begin
      rd_grant_o <= rd_grant_d;
      rd_done_o  <= rd_done_d;
      wr_grant_o <= wr_grant_d;
      wr_done_o  <= wr_done_d;
      bus_req_o  <= bus_req_d;
      bus_size_o <= bus_size_d;
      busy_o     <= busy_d;
      error_o    <= error_d;
      err_code_o <= err_code_d;
    end
  end

  // Beats seen while still requesting are ignored; the count starts in ARB_OWN.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      owner      <= ARB_RD;
      beats_need <= '0;
      beat_cnt   <= '0;
      tmo_cnt    <= '0;
    end else begin
      if (latch) begin
        owner      <= pick;
        beats_need <= sel_beats;
      end
      if (stop_i) begin
        beat_cnt <= '0;
        tmo_cnt  <= '0;
      end else begin
        case (state)
          ARB_REQ: begin
            beat_cnt <= '0;
            tmo_cnt  <= bus_grant_i ? '0 : tmo_cnt + TMO_ONE;
          end
          ARB_OWN: begin
            if (bus_beat_i) begin
              beat_cnt <= beat_cnt + 3'd1;
              tmo_cnt  <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_ONE;
            end
          end
          default: begin
            beat_cnt <= '0;
            tmo_cnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ip_codma_bus_arbiter.sv
// Directed and randomized checks of the CODMA bus arbiter against a
// transaction-level model of ownership, burst length and error outcomes.
module tb_ip_codma_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       stop = 1'b0;
  logic       rd_req = 1'b0;
  logic [3:0] rd_size = '0;
  logic       rd_grant;
  logic       rd_done;
  logic       wr_req = 1'b0;
  logic [3:0] wr_size = '0;
  logic       wr_grant;
  logic       wr_done;
  logic       bus_req;
  logic [3:0] bus_size;
  logic       bus_grant = 1'b0;
  logic       bus_beat = 1'b0;
  logic       bus_error = 1'b0;
  logic       busy;
  logic       error;
  logic [1:0] err_code;

  int total  = 0;
  int passed = 0;
  int beats_of [16];
  bit last_owner;  // 0 = read, 1 = write

  logic [8:0] obs;
  assign obs = {rd_grant, rd_done, wr_grant, wr_done, bus_req, busy, error, err_code};

  ip_codma_bus_arbiter #(.TIMEOUT_CYCLES(256), .CNT_W(9)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .stop_i      (stop),
    .rd_req_i    (rd_req),
    .rd_size_i   (rd_size),
    .rd_grant_o  (rd_grant),
    .rd_done_o   (rd_done),
    .wr_req_i    (wr_req),
    .wr_size_i   (wr_size),
    .wr_grant_o  (wr_grant),
    .wr_done_o   (wr_done),
    .bus_req_o   (bus_req),
    .bus_size_o  (bus_size),
    .bus_grant_i (bus_grant),
    .bus_beat_i  (bus_beat),
    .bus_error_i (bus_error),
    .busy_o      (busy),
    .error_o     (error),
    .err_code_o  (err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Order: rd_grant rd_done wr_grant wr_done bus_req busy error err_code
  function automatic logic [8:0] ev(input logic rg, rdn, wg, wdn, br, bz, er,
                                    input logic [1:0] ec);
    return {rg, rdn, wg, wdn, br, bz, er, ec};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    {stop, rd_req, wr_req, bus_grant, bus_beat, bus_error} = '0;
    reset = 1'b1;
    repeat (2) tick();
    #3 reset = 1'b0;
    last_owner = 1'b1;
    tick();
  endtask

  // One complete burst; owner and length come from the round-robin rule
  // and the size table, not from the DUT.
  task automatic burst(input logic rq, input logic [3:0] rs, input logic wq,
                       input logic [3:0] ws, input int gdelay, input int max_gap,
                       input string tag);
    bit own;
    int n;
    logic [3:0] sz;
    own = (rq && wq) ? !last_owner : !rq;
    sz  = own ? ws : rs;
    n   = beats_of[sz];
    rd_req = rq; rd_size = rs; wr_req = wq; wr_size = ws;
    tick();
    chk({tag, ".req"}, obs, ev(0, 0, 0, 0, 1, 1, 0, 0));
    chk({tag, ".size"}, bus_size, sz);
    repeat (gdelay) begin
      bus_beat = 1'($urandom_range(0, 1));
      tick();
      chk({tag, ".wait"}, obs, ev(0, 0, 0, 0, 1, 1, 0, 0));
    end
    bus_beat = 1'b0;
    bus_grant = 1'b1;
    tick();
    bus_grant = 1'b0;
    chk({tag, ".grant"}, obs, ev(!own, 0, own, 0, 1, 1, 0, 0));
    for (int b = 1; b <= n; b++) begin
      repeat ($urandom_range(0, max_gap)) begin
        tick();
        chk({tag, ".gap"}, obs, ev(!own, 0, own, 0, 1, 1, 0, 0));
      end
      if ($urandom_range(0, 3) == 0) begin
        if (own) wr_req = 1'b0; else rd_req = 1'b0;
      end
      bus_beat = 1'b1;
      tick();
      bus_beat = 1'b0;
      if (b == n) chk({tag, ".done"}, obs, ev(0, !own, 0, own, 0, 1, 0, 0));
      else        chk({tag, ".beat"}, obs, ev(!own, 0, own, 0, 1, 1, 0, 0));
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    tick();
    chk({tag, ".idle"}, obs, ev(0, 0, 0, 0, 0, 0, 0, 0));
    last_owner = own;
  endtask

  initial begin
    logic [3:0] legal [3];
    legal[0] = 4'd3; legal[1] = 4'd8; legal[2] = 4'd9;
    foreach (beats_of[i]) beats_of[i] = 0;
    beats_of[3] = 1;
    beats_of[8] = 3;
    beats_of[9] = 4;

    // Reset state
    apply_reset();
    chk("reset.out", obs, ev(0, 0, 0, 0, 0, 0, 0, 0));
    chk("reset.size", bus_size, 4'd0);

    // 1: single read burst of 4 beats, grant sampled on the third edge
    burst(1, 4'd9, 0, 4'd0, 1, 2, "t1");

    // 2: simultaneous requests alternate starting with read
    apply_reset();
    repeat (3) burst(1, 4'd3, 1, 4'd3, 0, 2, "t2");

    // 3: illegal size on write
    wr_req = 1'b1; wr_size = 4'd5;
    tick();
    chk("t3.err", obs, ev(0, 0, 0, 0, 0, 1, 1, 1));
    rd_req = 1'b1; rd_size = 4'd3;
    repeat (3) begin
      tick();
      chk("t3.hold", obs, ev(0, 0, 0, 0, 0, 1, 1, 1));
    end
    rd_req = 1'b0; wr_req = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t3.stop", obs, ev(0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    chk("t3.idle", obs, ev(0, 0, 0, 0, 0, 0, 0, 0));

    // 4: beat timeout after two of three beats
    rd_req = 1'b1; rd_size = 4'd8;
    tick();
    chk("t4.req", obs, ev(0, 0, 0, 0, 1, 1, 0, 0));
    bus_grant = 1'b1;
    tick();
    bus_grant = 1'b0;
    chk("t4.grant", obs, ev(1, 0, 0, 0, 1, 1, 0, 0));
    bus_beat = 1'b1;
    repeat (2) begin
      tick();
      chk("t4.beat", obs, ev(1, 0, 0, 0, 1, 1, 0, 0));
    end
    bus_beat = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      tick();
      chk("t4.silent", obs, ev(1, 0, 0, 0, 1, 1, 0, 0));
    end
    tick();
    chk("t4.timeout", obs, ev(0, 0, 0, 0, 0, 1, 1, 2));
    rd_req = 1'b0;
    repeat (2) begin
      tick();
      chk("t4.hold", obs, ev(0, 0, 0, 0, 0, 1, 1, 2));
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t4.stop", obs, ev(0, 0, 0, 0, 0, 0, 0, 0));

    // 5: bus error on the final beat wins over completion
    wr_req = 1'b1; wr_size = 4'd9;
    tick();
    chk("t5.req", obs, ev(0, 0, 0, 0, 1, 1, 0, 0));
    bus_grant = 1'b1;
    tick();
    bus_grant = 1'b0;
    chk("t5.grant", obs, ev(0, 0, 1, 0, 1, 1, 0, 0));
    bus_beat = 1'b1;
    repeat (3) begin
      tick();
      chk("t5.beat", obs, ev(0, 0, 1, 0, 1, 1, 0, 0));
    end
    bus_error = 1'b1;
    tick();
    bus_beat = 1'b0; bus_error = 1'b0;
    chk("t5.buserr", obs, ev(0, 0, 0, 0, 0, 1, 1, 3));
    wr_req = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t5.stop", obs, ev(0, 0, 0, 0, 0, 0, 0, 0));
    wr_req = 1'b1;
    tick();
    bus_grant = 1'b1;
    tick();
    bus_grant = 1'b0;
    bus_beat = 1'b1;
    tick();
    bus_beat = 1'b0;
    chk("t5.own2", obs, ev(0, 0, 1, 0, 1, 1, 0, 0));
    stop = 1'b1; bus_error = 1'b1; wr_req = 1'b0;
    tick();
    stop = 1'b0; bus_error = 1'b0;
    chk("t5.stop_err", obs, ev(0, 0, 0, 0, 0, 0, 0, 0));
    // Aborted bursts leave the history alone, so the tie still goes to write
    burst(1, 4'd3, 1, 4'd8, 0, 1, "t5.rr");
    // Bus error while still requesting
    rd_req = 1'b1; rd_size = 4'd3;
    tick();
    bus_error = 1'b1;
    tick();
    bus_error = 1'b0; rd_req = 1'b0;
    chk("t5.reqerr", obs, ev(0, 0, 0, 0, 0, 1, 1, 3));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t5.stop3", obs, ev(0, 0, 0, 0, 0, 0, 0, 0));

    // 6: asynchronous reset in the middle of a burst
    rd_req = 1'b1; rd_size = 4'd9;
    tick();
    bus_grant = 1'b1;
    tick();
    bus_grant = 1'b0;
    bus_beat = 1'b1;
    tick();
    bus_beat = 1'b0;
    chk("t6.own", obs, ev(1, 0, 0, 0, 1, 1, 0, 0));
    #2 reset = 1'b1;
    #1;
    chk("t6.async", obs, ev(0, 0, 0, 0, 0, 0, 0, 0));
    chk("t6.size", bus_size, 4'd0);
    rd_req = 1'b0;
    tick();
    #3 reset = 1'b0;
    last_owner = 1'b1;
    tick();
    chk("t6.after", obs, ev(0, 0, 0, 0, 0, 0, 0, 0));
    burst(1, 4'd9, 0, 4'd0, 2, 2, "t6.new");

    // Randomized bursts
    for (int i = 0; i < 24; i++) begin
      logic rq, wq;
      rq = 1'($urandom_range(0, 1));
      wq = rq ? 1'($urandom_range(0, 1)) : 1'b1;
      burst(rq, legal[$urandom_range(0, 2)], wq, legal[$urandom_range(0, 2)],
            $urandom_range(0, 4), 3, "rnd");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ip_codma_bus_arbiter.md
Name: ip_codma_bus_arbiter

Overview:
Shares the single CODMA memory-bus master port between the read machine and the write machine. Each machine requests a burst with a size code. The arbiter:
- picks one requester using round-robin;
- requests the bus and forwards ownership;
- counts data beats to detect burst end, then releases the bus.

It also enforces a grant/beat timeout and converts bus errors into a sticky error for the top-level DMA FSM.

Parameters:
TIMEOUT_CYCLES, 256, max cycles allowed in ARB_REQ or ARB_OWN before timeout error.
CNT_W, 9, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk_i  in  1  clock, rising edge.
reset_i  in  1  asynchronous, active-high reset.
stop_i  in  1  synchronous abort from DMA FSM; also clears sticky error.
rd_req_i  in  1  read machine requests the bus; level, held until rd_done_o.
rd_size_i  in  4  read burst size code, sampled when rd is selected.
rd_grant_o  out  1  read machine owns the bus.
rd_done_o  out  1  one-cycle pulse: read burst complete, bus released.
wr_req_i  in  1  write machine requests the bus.
wr_size_i  in  4  write burst size code.
wr_grant_o  out  1  write machine owns the bus.
wr_done_o  out  1  one-cycle pulse: write burst complete.
bus_req_o  out  1  request to memory bus.
bus_size_o  out  4  latched size code of the current owner.
bus_grant_i  in  1  memory bus grant.
bus_beat_i  in  1  one 64-bit beat transferred (read_valid or write accept).
bus_error_i  in  1  bus error.
busy_o  out  1  state != ARB_IDLE.
error_o  out  1  sticky error flag.
err_code_o  out  2  0 none, 1 illegal size, 2 timeout, 3 bus error.

Behaviour:
- All outputs are registered. Reset values: every output 0; state ARB_IDLE; last_owner = WR, so read wins the first tie; counters 0.
- Size decode (package function), beats of 64 bits:
  - code 3 → 1 beat;
  - code 8 → 3 beats;
  - code 9 → 4 beats;
  - any other code is illegal.
- States: ARB_IDLE, ARB_REQ, ARB_OWN, ARB_RELEASE, ARB_ERROR.
- ARB_IDLE:
  - If only one requester is active, select it. If both are active, select !last_owner.
  - Latch owner and size into bus_size_o.
  - Legal size → ARB_REQ, with bus_req_o=1 from the next cycle (1-cycle latency from req to bus_req_o).
  - Illegal size → ARB_ERROR, err_code 1.
- ARB_REQ:
  - Hold bus_req_o and increment the timeout counter.
  - On bus_grant_i → ARB_OWN; owner's grant_o=1 the next cycle; beat_cnt=0, timeout=0.
- ARB_OWN:
  - On each bus_beat_i, beat_cnt++ and reset timeout to 0; otherwise timeout++.
  - When the beat that makes beat_cnt equal the decoded beats arrives → ARB_RELEASE.
  - Beats are counted even if grant_o has not yet risen; beats seen in ARB_REQ are ignored.
- ARB_RELEASE (1 cycle):
  - grant_o=0, bus_req_o=0, owner's done_o=1.
  - last_owner ← owner; then → ARB_IDLE.
  - A new request may be accepted in the following cycle; there is no back-to-back ownership without an IDLE cycle.
- Timeout: counter == TIMEOUT_CYCLES in ARB_REQ or ARB_OWN → ARB_ERROR, err_code 2.
- bus_error_i in any state other than ARB_IDLE/ARB_ERROR → ARB_ERROR, err_code 3.
- ARB_ERROR:
  - grants, bus_req_o and done_o are 0; error_o=1.
  - Stays here until stop_i; new requests are ignored.
- stop_i has highest priority in every state:
  - next state ARB_IDLE, no done pulse;
  - clears error_o, err_code_o and counters;
  - last_owner is unchanged.
- Simultaneous events, priority: stop_i > bus_error_i > timeout > final beat. Error on the last beat means no done pulse.
- Requester dropping req while owning is ignored; the burst runs to completion.
- Reset asserted mid-burst: all outputs drop asynchronously; no done pulse.

Decomposition:
- ip_codma_pkg gains:
  - arb_state_t enum;
  - arb_owner_t (ARB_RD, ARB_WR);
  - size code constants SIZE_2W=3, SIZE_6W=8, SIZE_8W=9;
  - function size_to_beats(logic [3:0]) returning 3-bit beats, 0 meaning illegal;
  - err_code constants.
- One sub-module: ip_codma_rr_picker (2-way combinational round-robin select plus last_owner register).

Test Plan:
1. Reset, then rd_req_i=1 with size 9, bus_grant_i at cycle 3, four beats → bus_req_o rises at cycle 1; rd_grant_o high after the grant; rd_done_o pulses exactly once after the 4th beat; bus_req_o falls the same cycle.
2. rd_req and wr_req raised the same cycle, both size 3, repeated → first grant goes to rd, then wr, then rd (alternation); each done pulse follows exactly 1 beat.
3. wr_req with size 5 → ARB_ERROR, error_o=1, err_code_o=1, bus_req_o never asserted; stop_i clears error_o and returns to idle.
4. rd_req size 8, grant, 2 beats, then silence → ARB_ERROR with err_code_o=2 when the counter reaches 256; rd_grant_o drops and rd_done_o never pulses.
5. wr burst size 9: bus_error_i on the 4th beat → error wins, err_code_o=3, no wr_done_o; stop_i and bus_error_i together in a new burst → IDLE, error_o=0.
6. reset_i asserted mid-burst during ARB_OWN → all outputs 0 immediately (asynchronous); after release, a new rd_req completes normally.
